// File: rtl/regfile_wb_arbiter_if.sv
// Bundle connecting the regfile writeback arbiter to its writeback sources and the regfile.
// The slave modport is the arbiter's view; master is the source/regfile side.
interface regfile_wb_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3
);
    logic                     hold;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [5*NUM_REQ-1:0]     req_rd_addr;
    logic [WIDTH*NUM_REQ-1:0] req_data;
    logic                     w_en;
    logic [4:0]               rd_addr;
    logic [WIDTH-1:0]         w_data;
    logic [2:0]               grant_id;
    logic [4:0]               ra_addr;
    logic [4:0]               rb_addr;
    logic                     ra_fwd_hit;
    logic                     rb_fwd_hit;
    logic [WIDTH-1:0]         ra_fwd_data;
    logic [WIDTH-1:0]         rb_fwd_data;

    modport slave (
        input  hold, req_valid, req_rd_addr, req_data, ra_addr, rb_addr,
        output req_ready, w_en, rd_addr, w_data, grant_id,
               ra_fwd_hit, rb_fwd_hit, ra_fwd_data, rb_fwd_data
    );

    modport master (
        output hold, req_valid, req_rd_addr, req_data, ra_addr, rb_addr,
        input  req_ready, w_en, rd_addr, w_data, grant_id,
               ra_fwd_hit, rb_fwd_hit, ra_fwd_data, rb_fwd_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NUM_REQ writeback sources.
// Optional macro WB_BYPASS_EN enables combinational forwarding of the pending write to read ports A/B.
module regfile_wb_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    logic [7:0]         zero_req_s;
    logic [7:0]         nz_req_s;
    logic [2:0]         last_grant_r;
    logic               grant_valid_s;
    logic [2:0]         grant_idx_s;
    logic [3:0]         cand_s;
    logic               take_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [4:0]         win_addr_s;
    logic [WIDTH-1:0]   win_data_s;
    logic               w_en_r;
    logic [4:0]         rd_addr_r;
    logic [WIDTH-1:0]   w_data_r;
    logic [2:0]         grant_id_r;

    // Split valid requests into x0 sinks and real writes; padded to 8 so any 3-bit index is legal.
    always_comb begin
        zero_req_s = 8'h00;
        nz_req_s   = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            zero_req_s[i] = bus.req_valid[i] & (bus.req_rd_addr[5*i +: 5] == 5'd0);
            nz_req_s[i]   = bus.req_valid[i] & (bus.req_rd_addr[5*i +: 5] != 5'd0);
        end
    end

    // Round-robin search starting just after the last accepted winner, with wrap-around.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 3'd0;
        cand_s        = 4'd0;
        take_s        = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s        = {1'b0, last_grant_r} + 4'(k);
            cand_s        = (cand_s >= 4'(NUM_REQ)) ? (cand_s - 4'(NUM_REQ)) : cand_s;
            take_s        = ~grant_valid_s & nz_req_s[cand_s[2:0]];
            grant_idx_s   = take_s ? cand_s[2:0] : grant_idx_s;
            grant_valid_s = grant_valid_s | take_s;
        end
    end

    // Ready generation and winner payload steering; hold blocks every acceptance.
    always_comb begin
        accept_s   = grant_valid_s & ~bus.hold;
        ready_s    = {NUM_REQ{1'b0}};
        win_addr_s = 5'd0;
        win_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_s[i] = ~bus.hold & (zero_req_s[i] | (grant_valid_s & (grant_idx_s == 3'(i))));
            win_addr_s = (grant_idx_s == 3'(i)) ? bus.req_rd_addr[5*i +: 5] : win_addr_s;
            win_data_s = (grant_idx_s == 3'(i)) ? bus.req_data[WIDTH*i +: WIDTH] : win_data_s;
        end
    end

    // Write register and round-robin pointer; w_en drops whenever no real write is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_en_r       <= 1'b0;
            rd_addr_r    <= 5'd0;
            w_data_r     <= {WIDTH{1'b0}};
            grant_id_r   <= 3'd0;
            last_grant_r <= 3'(NUM_REQ - 1);
        end else begin
            w_en_r <= accept_s;
            if (accept_s) begin
                rd_addr_r    <= win_addr_s;
                w_data_r     <= win_data_s;
                grant_id_r   <= grant_idx_s;
                last_grant_r <= grant_idx_s;
            end else begin
                rd_addr_r    <= rd_addr_r;
                w_data_r     <= w_data_r;
                grant_id_r   <= grant_id_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.w_en      = w_en_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.w_data    = w_data_r;
    assign bus.grant_id  = grant_id_r;

`ifdef WB_BYPASS_EN
    // Readers in the cycle after acceptance see the pending value before the regfile updates.
    assign bus.ra_fwd_hit  = w_en_r & (rd_addr_r == bus.ra_addr) & (bus.ra_addr != 5'd0);
    assign bus.rb_fwd_hit  = w_en_r & (rd_addr_r == bus.rb_addr) & (bus.rb_addr != 5'd0);
    assign bus.ra_fwd_data = w_data_r;
    assign bus.rb_fwd_data = w_data_r;
`else
    logic unused_bypass_s;
    assign unused_bypass_s = ^{bus.ra_addr, bus.rb_addr};
    assign bus.ra_fwd_hit  = 1'b0;
    assign bus.rb_fwd_hit  = 1'b0;
    assign bus.ra_fwd_data = {WIDTH{1'b0}};
    assign bus.rb_fwd_data = {WIDTH{1'b0}};
`endif

endmodule
